// File: rtl/cpu_bus_interface.sv
// cpu_bus_interface: takes one 16-bit read/write request from the 6502 core
// and serialises it onto the 8-bit TinyTapeout pins. Address goes out high
// byte first, then low byte. The data phase supports wait states, rdy
// stretching and a timeout, and the result goes back to the core as a
// one-cycle response pulse.
module cpu_bus_interface #(
    parameter int WAIT_STATES = 0,   // extra data-phase cycles before rdy is considered (0..15)
    parameter int TIMEOUT     = 64   // rdy-low data-phase cycles tolerated before abort (1..255)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_rw,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [7:0]  rsp_rdata,
    input  logic        rdy,
    output logic [7:0]  pin_addr,
    output logic [7:0]  pin_data_out,
    input  logic [7:0]  pin_data_in,
    output logic [7:0]  pin_data_oe,
    output logic [1:0]  pin_phase
);

    // The encoding matches the pin_phase values seen on the bus.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR_HI = 2'd1,
        S_ADDR_LO = 2'd2,
        S_DATA    = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);
    // to_cnt counts stalls already taken, so the abort fires on the stall
    // that would bring it to TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic [7:0]  pin_addr_q, pin_addr_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  pin_phase_q;

    // State and datapath registers. Reset drops any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 16'h0000;
            rw_q        <= 1'b0;
            wdata_q     <= 8'h00;
            wait_cnt_q  <= 4'd0;
            to_cnt_q    <= 8'd0;
            pin_addr_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 8'h00;
            pin_phase_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            to_cnt_q    <= to_cnt_d;
            pin_addr_q  <= pin_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            pin_phase_q <= state_d;
        end
    end

    // Next-state logic: request capture, address serialisation and the
    // data-phase wait / stretch / timeout rules.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        wait_cnt_d  = wait_cnt_q;
        to_cnt_d    = to_cnt_q;
        pin_addr_d  = pin_addr_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            S_IDLE: begin
                // req_ready is high throughout IDLE, so req_valid alone accepts.
                if (req_valid) begin
                    addr_d     = req_addr;
                    rw_d       = req_rw;
                    wdata_d    = req_wdata;
                    pin_addr_d = req_addr[15:8];
                    state_d    = S_ADDR_HI;
                end
            end
            S_ADDR_HI: begin
                pin_addr_d = addr_q[7:0];
                state_d    = S_ADDR_LO;
            end
            S_ADDR_LO: begin
                wait_cnt_d = WAIT_LD;
                to_cnt_d   = 8'd0;
                state_d    = S_DATA;
            end
            S_DATA: begin
                if (wait_cnt_q != 4'd0) begin
                    // Wait states run out before rdy is looked at.
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else if (rdy) begin
                    rsp_valid_d = 1'b1;
                    if (!rw_q) begin
                        rsp_rdata_d = pin_data_in;
                    end
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                    if (to_cnt_q == TO_LAST) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready    = (state_q == S_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign pin_addr     = pin_addr_q;
    assign pin_phase    = pin_phase_q;
    // Write data is driven for the whole data phase, including wait and stretch cycles.
    assign pin_data_oe  = (state_q == S_DATA && rw_q) ? 8'hFF : 8'h00;
    assign pin_data_out = (state_q == S_DATA && rw_q) ? wdata_q : 8'h00;

endmodule

// File: doc/cpu_bus_interface.md
Name: cpu_bus_interface

Overview:
- Sits between the 6502 core datapath and the TinyTapeout pins; the core's memory-access stage feeds this block, and this block drives the external bus.
- Accepts one 16-bit read/write request at a time and serialises it onto the 8-bit address pins as high byte, then low byte.
- Runs a data phase on the bidirectional pins, with wait-state, ready-stretch and timeout support, then returns read data or an error to the core.

Parameters:
WAIT_STATES, 0, extra data-phase cycles inserted before sampling/ending; 0..15
TIMEOUT, 64, max consecutive data-phase cycles with rdy low before abort; 1..255

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core request present
req_ready  output  1  block can accept request this cycle
req_addr  input  16  target address
req_rw  input  1  0 = read, 1 = write
req_wdata  input  8  write data
rsp_valid  output  1  one-cycle pulse: access complete
rsp_err  output  1  qualifies rsp_valid: 1 = timeout abort
rsp_rdata  output  8  last successfully read byte
rdy  input  1  external ready; low stretches data phase
pin_addr  output  8  to uo_out: multiplexed address byte
pin_data_out  output  8  to uio_out
pin_data_in  input  8  from uio_in
pin_data_oe  output  8  to uio_oe, 1 = drive
pin_phase  output  2  bus phase: 0 IDLE, 1 ADDR_HI, 2 ADDR_LO, 3 DATA

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Assertion at any time forces IDLE immediately.
- Reset values: req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0x00, pin_addr = 0x00, pin_data_out = 0x00, pin_data_oe = 0x00, pin_phase = 0, wait and timeout counters = 0.
- Reset mid-access: the access is dropped and no rsp_valid is issued.
- Handshake: a request is accepted on a rising edge where req_valid & req_ready.
  - req_addr, req_rw and req_wdata are captured into internal registers at that edge; later changes on those inputs have no effect.
  - req_ready = 1 only in IDLE.
- FSM:
  - IDLE -> ADDR_HI on accept.
  - ADDR_HI (1 cycle): pin_addr = addr[15:8], then -> ADDR_LO.
  - ADDR_LO (1 cycle): pin_addr = addr[7:0], then -> DATA.
  - DATA: pin_addr holds addr[7:0]. On entry, load wait_cnt = WAIT_STATES and to_cnt = 0.
- DATA cycle rules:
  - If wait_cnt != 0: decrement wait_cnt; rdy is ignored.
  - Else if rdy = 1: complete the access and go to IDLE. For a read, capture pin_data_in into rsp_rdata at this edge.
  - Else: increment to_cnt. When to_cnt reaches TIMEOUT, abort to IDLE with err.
- Write drive: in DATA for a write, pin_data_out = wdata and pin_data_oe = 0xFF for every DATA cycle, including wait and stretch cycles. Otherwise pin_data_out = 0x00 and pin_data_oe = 0x00.
- Response:
  - rsp_valid pulses high for exactly the first IDLE cycle after DATA.
  - rsp_err = 1 in that cycle only when aborted by timeout; it is 0 whenever rsp_valid = 0.
  - Writes and aborts leave rsp_rdata unchanged.
- Back-to-back: a new request may be accepted in the same cycle rsp_valid is high. With WAIT_STATES = 0 and rdy = 1, the access period is 4 cycles.
- Latency: accept edge to rsp_valid high = 3 + WAIT_STATES + stretch cycles.
- pin_addr holds its last value in IDLE.
- pin_phase is a registered decode of the state.

Test Plan:
- Read, WAIT_STATES = 0, rdy = 1: request addr 0x12A4, pin_data_in = 0x5C.
  - Phases 1, 2, 3 over 3 cycles, with pin_addr = 0x12, 0xA4, 0xA4.
  - rsp_valid pulses 3 cycles after accept; rsp_rdata = 0x5C, rsp_err = 0, oe = 0x00 throughout.
- Write 0x3F to 0xFFFE: pin_addr = 0xFF then 0xFE.
  - During DATA, pin_data_out = 0x3F and oe = 0xFF; oe = 0x00 before and after.
  - rsp_valid pulses and rsp_rdata is unchanged.
- WAIT_STATES = 2 with rdy held low 3 extra cycles, then read 0x81:
  - DATA lasts 6 cycles and rsp_valid arrives 8 cycles after accept.
  - pin_data_in changes during the stretch are not captured; rsp_rdata = 0x81.
- Back-to-back: req_valid held high for two reads, with req_addr/req_rdata changed mid-access.
  - Second accept occurs in the rsp_valid cycle; accepts are 4 cycles apart.
  - The first access uses its captured address.
- Timeout with TIMEOUT = 4, rdy stuck low: after 4 stretched DATA cycles the block returns to IDLE.
  - rsp_valid = 1 and rsp_err = 1 for one cycle; rsp_rdata keeps its previous value.
- Reset asserted in ADDR_LO: all outputs take their reset values immediately, with no rsp_valid.
  - After release, a new request completes normally.
